// File: rtl/cnt_pkg.sv
// Shared types and constants for the up/down counter, its monitor and the benches.
package cnt_pkg;

    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        TRACK
    } state_e;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        HOLD,
        JUMP
    } step_e;

endpackage

// File: rtl/cnt_monitor_step_classify.sv
// Combinational step classifier: class of the modular delta prev -> cnt, plus wrap detection.
module step_classify
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] cnt_i,
    output step_e            step_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta  = cnt_i - prev_i;
        step_o = JUMP;
        if (delta == '0) begin
            step_o = HOLD;
        end else if (delta == WIDTH'(1)) begin
            step_o = UP;
        end else if (delta == '1) begin
            step_o = DOWN;
        end
        wrap_o = ((step_o == UP) && (prev_i == '1)) ||
                 ((step_o == DOWN) && (prev_i == '0));
    end

endmodule

// File: rtl/cnt_monitor.sv
// Passive count-integrity monitor: locks onto an up/down sequence and flags
// illegal steps, wrap-arounds, reversals and holds with registered pulses.
module cnt_monitor
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH     = CNT_WIDTH,
    parameter int unsigned LOCK_LEN  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_err,
    input  logic [WIDTH-1:0]     cnt_in,
    output logic                 locked,
    output logic                 dir_out,
    output logic                 step_err,
    output logic                 wrap,
    output logic                 dir_chg,
    output logic                 hold,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned SW = $clog2(LOCK_LEN + 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic                 sdir_q, sdir_d;
    logic                 locked_q, locked_d;
    logic                 dir_q, dir_d;
    logic                 step_err_q, step_err_d;
    logic                 wrap_q, wrap_d;
    logic                 dir_chg_q, dir_chg_d;
    logic                 hold_q, hold_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    step_e step;
    logic  step_wrap;
    logic  is_move;
    logic  step_up;

    step_classify #(
        .WIDTH(WIDTH)
    ) u_classify (
        .prev_i(prev_q),
        .cnt_i (cnt_in),
        .step_o(step),
        .wrap_o(step_wrap)
    );

    assign is_move = (step == UP) || (step == DOWN);
    assign step_up = (step == UP);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        streak_d   = streak_q;
        sdir_d     = sdir_q;
        locked_d   = locked_q;
        dir_d      = dir_q;
        step_err_d = 1'b0;
        wrap_d     = 1'b0;
        dir_chg_d  = 1'b0;
        hold_d     = 1'b0;
        err_d      = clr_err ? '0 : err_q;

        if (!en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else begin
            prev_d = cnt_in;
            unique case (state_q)
                IDLE: begin
                    state_d  = SYNC;
                    streak_d = '0;
                    locked_d = 1'b0;
                end
                SYNC: begin
                    hold_d = (step == HOLD);
                    wrap_d = step_wrap;
                    if (is_move) begin
                        // A zero streak has no direction yet, so any move starts a new run.
                        if ((streak_q != '0) && (sdir_q == step_up)) begin
                            streak_d = streak_q + 1'b1;
                        end else begin
                            streak_d = SW'(1);
                            sdir_d   = step_up;
                        end
                        if (streak_d == SW'(LOCK_LEN)) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                            dir_d    = sdir_d;
                        end
                    end else if (step == JUMP) begin
                        streak_d = '0;
                    end
                end
                TRACK: begin
                    hold_d = (step == HOLD);
                    wrap_d = step_wrap;
                    if (is_move && (step_up != dir_q)) begin
                        dir_d     = step_up;
                        dir_chg_d = 1'b1;
                    end else if (step == JUMP) begin
                        step_err_d = 1'b1;
                        locked_d   = 1'b0;
                        streak_d   = '0;
                        state_d    = SYNC;
                        // Increment after any clear so a coincident error still counts.
                        if (err_d != '1) begin
                            err_d = err_d + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            streak_q   <= '0;
            sdir_q     <= 1'b0;
            locked_q   <= 1'b0;
            dir_q      <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            dir_chg_q  <= 1'b0;
            hold_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            streak_q   <= streak_d;
            sdir_q     <= sdir_d;
            locked_q   <= locked_d;
            dir_q      <= dir_d;
            step_err_q <= step_err_d;
            wrap_q     <= wrap_d;
            dir_chg_q  <= dir_chg_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    assign locked   = locked_q;
    assign dir_out  = dir_q;
    assign step_err = step_err_q;
    assign wrap     = wrap_q;
    assign dir_chg  = dir_chg_q;
    assign hold     = hold_q;
    assign err_cnt  = err_q;

endmodule
